// File: rtl/sw_pkg.sv
// Shared stopwatch types: BCD digit, packed MM:SS.cc time word and digit limits.
// The seven-segment display driver imports the same definitions.
package sw_pkg;

  typedef logic [3:0] bcd_t;

  typedef struct packed {
    bcd_t min_t;
    bcd_t min_o;
    bcd_t sec_t;
    bcd_t sec_o;
    bcd_t cs_t;
    bcd_t cs_o;
  } sw_time_t;

  localparam bcd_t DIG_MAX_UNITS = 4'd9;
  localparam bcd_t DIG_MAX_TENS  = 4'd5;

endpackage

// File: rtl/sw_time_counter_bcd_digit.sv
// One BCD digit of the time chain: counts 0..MAX on inc and reports a
// combinational carry so a whole chain settles within a single edge.
module bcd_digit
  import sw_pkg::*;
#(
  parameter bcd_t MAX = DIG_MAX_UNITS
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output bcd_t q,
  output logic carry
);

  bcd_t q_r;

  // Values above MAX cannot arise, but they are treated like MAX so the digit self-recovers.
  assign carry = inc && (q_r >= MAX);
  assign q     = q_r;

  // Digit register with clear priority over increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_r <= 4'd0;
    end else if (clr) begin
      q_r <= 4'd0;
    end else if (inc) begin
      if (q_r >= MAX) begin
        q_r <= 4'd0;
      end else begin
        q_r <= q_r + 4'd1;
      end
    end else begin
      q_r <= q_r;
    end
  end

endmodule

// File: rtl/sw_time_counter.sv
// Stopwatch timebase: divides clk into centisecond ticks, keeps an MM:SS.cc
// BCD count, and provides lap hold, clear and a sticky wrap flag.
module sw_time_counter
  import sw_pkg::*;
#(
  parameter int unsigned TICK_DIV = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        clr,
  input  logic        lap,
  output logic [23:0] disp_bcd,
  output logic [23:0] live_bcd,
  output logic        lap_mode,
  output logic        tick,
  output logic        wrapped
);

  localparam int unsigned CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] presc_r;
  logic             inc_s;
  logic [5:0]       carry_s;
  sw_time_t         live_s;
  sw_time_t         lap_r;
  logic             lap_mode_r;
  logic             tick_r;
  logic             wrapped_r;

  assign inc_s = en && !clr && (presc_r == PRE_LAST);

  // Prescaler: advances only while enabled, so a pause keeps the partial interval.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_r <= '0;
    end else if (clr) begin
      presc_r <= '0;
    end else if (en) begin
      if (inc_s) begin
        presc_r <= '0;
      end else begin
        presc_r <= presc_r + CNT_W'(1);
      end
    end else begin
      presc_r <= presc_r;
    end
  end

  bcd_digit #(.MAX(DIG_MAX_UNITS)) u_cs_o  (.clk(clk), .rst(rst), .clr(clr), .inc(inc_s),      .q(live_s.cs_o),  .carry(carry_s[0]));
  bcd_digit #(.MAX(DIG_MAX_UNITS)) u_cs_t  (.clk(clk), .rst(rst), .clr(clr), .inc(carry_s[0]), .q(live_s.cs_t),  .carry(carry_s[1]));
  bcd_digit #(.MAX(DIG_MAX_UNITS)) u_sec_o (.clk(clk), .rst(rst), .clr(clr), .inc(carry_s[1]), .q(live_s.sec_o), .carry(carry_s[2]));
  bcd_digit #(.MAX(DIG_MAX_TENS))  u_sec_t (.clk(clk), .rst(rst), .clr(clr), .inc(carry_s[2]), .q(live_s.sec_t), .carry(carry_s[3]));
  bcd_digit #(.MAX(DIG_MAX_UNITS)) u_min_o (.clk(clk), .rst(rst), .clr(clr), .inc(carry_s[3]), .q(live_s.min_o), .carry(carry_s[4]));
  bcd_digit #(.MAX(DIG_MAX_TENS))  u_min_t (.clk(clk), .rst(rst), .clr(clr), .inc(carry_s[4]), .q(live_s.min_t), .carry(carry_s[5]));

  // Status flags: tick marks the first cycle of a new value, wrapped sticks until clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_r    <= 1'b0;
      wrapped_r <= 1'b0;
    end else if (clr) begin
      tick_r    <= 1'b0;
      wrapped_r <= 1'b0;
    end else begin
      tick_r    <= inc_s;
      wrapped_r <= wrapped_r | carry_s[5];
    end
  end

  // Lap capture takes the pre-increment live value even on an increment edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lap_r      <= '0;
      lap_mode_r <= 1'b0;
    end else if (clr) begin
      lap_r      <= '0;
      lap_mode_r <= 1'b0;
    end else if (lap) begin
      if (!lap_mode_r) begin
        lap_r      <= live_s;
        lap_mode_r <= 1'b1;
      end else begin
        lap_r      <= lap_r;
        lap_mode_r <= 1'b0;
      end
    end else begin
      lap_r      <= lap_r;
      lap_mode_r <= lap_mode_r;
    end
  end

  // Display selects the frozen lap value or the live count.
  always_comb begin
    disp_bcd = live_s;
    if (lap_mode_r) begin
      disp_bcd = lap_r;
    end else begin
      disp_bcd = live_s;
    end
  end

  assign live_bcd = live_s;
  assign lap_mode = lap_mode_r;
  assign tick     = tick_r;
  assign wrapped  = wrapped_r;

endmodule

// File: tb/tb_sw_time_counter.sv
// Randomized self-checking bench: instance 0 (TICK_DIV=4) and instance 1
// (TICK_DIV=2, long wrap run) checked against a centisecond-count model.
module tb_sw_time_counter;

  logic        clk;
  logic        rst;
  logic [1:0]  en;
  logic [1:0]  clr;
  logic [1:0]  lap;
  logic [23:0] disp [2];
  logic [23:0] live [2];
  logic [1:0]  lap_mode;
  logic [1:0]  tick;
  logic [1:0]  wrapped;

  int n_tests;
  int n_fail;

  // Model state: total centiseconds, prescaler position, lap value and flags.
  int m_td   [2] = '{4, 2};
  int m_cnt  [2];
  int m_pre  [2];
  int m_lapv [2];
  bit m_lm   [2];
  bit m_wr   [2];
  bit m_tk   [2];

  sw_time_counter #(.TICK_DIV(4)) dut0 (
    .clk(clk), .rst(rst), .en(en[0]), .clr(clr[0]), .lap(lap[0]),
    .disp_bcd(disp[0]), .live_bcd(live[0]), .lap_mode(lap_mode[0]),
    .tick(tick[0]), .wrapped(wrapped[0])
  );

  sw_time_counter #(.TICK_DIV(2)) dut1 (
    .clk(clk), .rst(rst), .en(en[1]), .clr(clr[1]), .lap(lap[1]),
    .disp_bcd(disp[1]), .live_bcd(live[1]), .lap_mode(lap_mode[1]),
    .tick(tick[1]), .wrapped(wrapped[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] to_bcd(input int c);
    int cs, s, m;
    cs = c % 100;
    s  = (c / 100) % 60;
    m  = c / 6000;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(cs / 10), 4'(cs % 10)};
  endfunction

  function automatic void model_reset(input int i);
    m_cnt[i] = 0; m_pre[i] = 0; m_lapv[i] = 0;
    m_lm[i] = 1'b0; m_wr[i] = 1'b0; m_tk[i] = 1'b0;
  endfunction

  function automatic void model_step(input int i);
    bit inc;
    if (clr[i]) begin
      model_reset(i);
    end else begin
      inc = en[i] && (m_pre[i] == m_td[i] - 1);
      m_tk[i] = inc;
      if (lap[i]) begin
        if (!m_lm[i]) begin
          m_lapv[i] = m_cnt[i];
          m_lm[i] = 1'b1;
        end else begin
          m_lm[i] = 1'b0;
        end
      end
      if (en[i]) m_pre[i] = inc ? 0 : m_pre[i] + 1;
      if (inc) begin
        m_cnt[i] = m_cnt[i] + 1;
        if (m_cnt[i] == 360000) begin
          m_cnt[i] = 0;
          m_wr[i] = 1'b1;
        end
      end
    end
  endfunction

  task automatic step();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
  endtask

  task automatic check_inst(input int i);
    check($sformatf("live%0d", i), 32'(live[i]), 32'(to_bcd(m_cnt[i])));
    check($sformatf("disp%0d", i), 32'(disp[i]), 32'(m_lm[i] ? to_bcd(m_lapv[i]) : to_bcd(m_cnt[i])));
    check($sformatf("tick%0d", i), 32'(tick[i]), 32'(m_tk[i]));
    check($sformatf("lap_mode%0d", i), 32'(lap_mode[i]), 32'(m_lm[i]));
    check($sformatf("wrapped%0d", i), 32'(wrapped[i]), 32'(m_wr[i]));
  endtask

  initial begin
    int guard;
    n_tests = 0;
    n_fail  = 0;
    en = 2'b00; clr = 2'b00; lap = 2'b00;
    rst = 1'b0;

    // Reset asserted mid-cycle, released on a falling edge.
    #2 rst = 1'b1;
    #20;
    @(negedge clk);
    rst = 1'b0;
    model_reset(0);
    model_reset(1);
    #1;
    for (int i = 0; i < 2; i++) begin
      check("rst_live", 32'(live[i]), 32'h0);
      check("rst_disp", 32'(disp[i]), 32'h0);
      check("rst_flags", {29'd0, lap_mode[i], tick[i], wrapped[i]}, 32'h0);
    end

    // Continuous run: first increment on the 4th enabled edge, 00:01.00 after 400.
    en[0] = 1'b1;
    for (int c = 1; c <= 400; c++) begin
      step();
      check_inst(0);
      if (c == 3) check("pre_first_inc", 32'(live[0]), 32'h0);
      if (c == 4) check("first_inc", {7'd0, tick[0], live[0]}, {7'd0, 1'b1, 24'h000001});
    end
    check("run_400", 32'(live[0]), 32'h000100);

    // Pause keeps the partial interval.
    clr[0] = 1'b1; step(); clr[0] = 1'b0;
    check_inst(0);
    en[0] = 1'b1; step(); step();
    en[0] = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      check_inst(0);
      check("pause_tick", 32'(tick[0]), 32'h0);
    end
    en[0] = 1'b1;
    step(); check("resume1", 32'(live[0]), 32'h0);
    step(); check("resume2", {7'd0, tick[0], live[0]}, {7'd0, 1'b1, 24'h000001});
    check_inst(0);

    // Lap on the increment edge leaving 00:00.07.
    clr[0] = 1'b1; step(); clr[0] = 1'b0;
    guard = 0;
    while (!(m_cnt[0] == 7 && m_pre[0] == 3) && guard < 200) begin
      step();
      guard++;
    end
    check("lap_reach", 32'(guard < 200), 32'h1);
    lap[0] = 1'b1; step(); lap[0] = 1'b0;
    check("lap_disp", 32'(disp[0]), 32'h000007);
    check("lap_live", 32'(live[0]), 32'h000008);
    for (int c = 0; c < 20; c++) begin
      step();
      check_inst(0);
    end
    check("lap_frozen", 32'(disp[0]), 32'h000007);
    lap[0] = 1'b1; step(); lap[0] = 1'b0;
    check("lap_off_mode", 32'(lap_mode[0]), 32'h0);
    check("lap_off_disp", 32'(disp[0]), 32'(live[0]));
    check_inst(0);

    // Clear with lap on the same edge, then a full interval before the next increment.
    lap[0] = 1'b1; step(); lap[0] = 1'b0;
    check("clr_pre_mode", 32'(lap_mode[0]), 32'h1);
    clr[0] = 1'b1; lap[0] = 1'b1; step(); clr[0] = 1'b0; lap[0] = 1'b0;
    check("clr_out", {lap_mode[0], tick[0], wrapped[0], disp[0]}, 32'h0);
    check("clr_live", 32'(live[0]), 32'h0);
    for (int c = 1; c <= 4; c++) begin
      step();
      check_inst(0);
    end
    check("clr_restart", {7'd0, tick[0], live[0]}, {7'd0, 1'b1, 24'h000001});

    // Random en/lap/clr traffic on instance 0.
    for (int c = 0; c < 3000; c++) begin
      en[0]  = ($urandom_range(3) != 0);
      lap[0] = ($urandom_range(14) == 0);
      clr[0] = ($urandom_range(49) == 0);
      step();
      check_inst(0);
    end
    en[0] = 1'b0; lap[0] = 1'b0; clr[0] = 1'b0;

    // Long wrap run on instance 1: 720000 enabled cycles.
    en[1] = 1'b1;
    for (int c = 1; c <= 720000; c++) begin
      step();
      if (c % 49999 == 0 || m_cnt[1] >= 359998 || (m_wr[1] && m_cnt[1] < 2)) check_inst(1);
      if (c == 719998) check("pre_wrap", 32'(live[1]), 32'h595999);
    end
    check("wrap_live", 32'(live[1]), 32'h000000);
    check("wrap_flag", 32'(wrapped[1]), 32'h1);
    for (int c = 0; c < 10; c++) step();
    check("wrap_sticky", 32'(wrapped[1]), 32'h1);
    check_inst(1);

    // Clear also drops the sticky wrap flag.
    lap[1] = 1'b1; step(); lap[1] = 1'b0;
    check_inst(1);
    clr[1] = 1'b1; lap[1] = 1'b1; step(); clr[1] = 1'b0; lap[1] = 1'b0;
    check("clr_wrap", {lap_mode[1], tick[1], wrapped[1], disp[1]}, 32'h0);
    check_inst(1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
